ascon_perm: RTL
===============

# ascon_perm

Sequential driver for the combinational single-round core `ascon_pc`. It holds the 320-bit ASCON state in a register and applies p^a (12 rounds) or p^b (8 rounds, or any count 1..12) through one `ascon_pc` instance per clock. It sits between the AEAD128a mode controller and `ascon_pc`: it generates `round_i` and `S_i` for the core and captures its `S_o`, with a start/done handshake toward the controller.

## Interface
- Parameters: none. The round count is a run-time input.
- `clk_i`  in  1  clock; all state changes on the rising edge.
- `rst_i`  in  1  reset, asynchronous, active-high.
- `start_i`  in  1  request a permutation; sampled only when `busy_o` = 0.
- `rounds_i`  in  4  number of rounds, sampled with `start_i`. Legal values 1..12; 0 and 13..15 are treated as 12.
- `S_i`  in  320  input state, sampled with `start_i`.
- `S_o`  out  320  state register. Valid from the `done_o` cycle and held until the next accepted start.
- `busy_o`  out  1  high while rounds are in progress.
- `done_o`  out  1  one-cycle pulse when the final round has been written.
- `round_o`  out  4  round-constant index currently presented to `ascon_pc`. Debug/verification port.

## Operation
- State register `st`, round counter `rc` (4 bits), last-round count `last`.
- States:
  - IDLE, with `busy_o` = 0.
  - RUN, with `busy_o` = 1.
- IDLE with `start_i` = 1:
  - `st <= S_i`.
  - `rc <= 12 - n`, where n is the effective round count.
  - Go to RUN.
- RUN, each edge:
  - `st <= ascon_pc(round_i = rc, S_i = st)`.
  - If `rc` = 11: go to IDLE and set `done_o <= 1`.
  - Otherwise `rc <= rc + 1`.
- Round-constant indices applied are always 12-n .. 11, per the ASCON specification (p^8 uses indices 4..11).
- `round_o` = `rc` in RUN and 0 in IDLE.
- `start_i` during RUN is ignored; no queuing.
- `S_i` and `rounds_i` are don't-care outside the accepting cycle.
- `done_o` is registered and cleared on the following edge.
- Back-to-back: in the `done_o` cycle `busy_o` is already 0, so a `start_i` in that cycle is accepted.
- Reset (any time, including mid-run):
  - `st` = 0, `rc` = 0, state IDLE.
  - `S_o` = 0, `busy_o` = 0, `done_o` = 0, `round_o` = 0.
  - Any partial result is discarded.

## Timing
- Edge E0 samples `start_i`. Rounds are applied on edges E1..En.
- `busy_o` is high from after E0 until En.
- `done_o` is high for exactly the cycle after En.
- Start-to-done latency is n+1 cycles: p^12 takes 13, p^8 takes 9.
- Throughput: one permutation per n+1 cycles when starts are back-to-back.
- `S_o` is not meaningful during RUN; it shows intermediate states.

## Configuration
- `ASCON_PERM_UNROLL2_EN` defined:
  - Two chained `ascon_pc` instances (indices `rc` and `rc+1`); each RUN edge applies two rounds and `rc <= rc + 2`.
  - If `rc` = 11 only one round remains: the first instance's output is written and the run finishes.
  - Latency is ceil(n/2)+1 cycles: p^12 takes 7, p^8 takes 5, n = 3 takes 3.
  - `round_o` shows the first instance's index.
- Not defined: a single instance and one round per cycle, as in Operation.
- Final `S_o` is bit-identical in both builds.

## Test plan
- Reset: assert `rst_i` asynchronously between edges → all outputs 0 immediately, with no clock edge required.
- p^12 with `S_i` = 0xfeedfacecafebeef repeated 5 times and `rounds_i` = 12:
  - `round_o` steps 0..11.
  - `done_o` is a single-cycle pulse 13 cycles after the start edge.
  - `S_o` equals a golden model of 12 sequential `ascon_pc` rounds.
- p^8 on the same input:
  - `round_o` steps 4..11.
  - `done_o` arrives after 9 cycles.
  - `S_o` matches the golden model for indices 4..11.
- Illegal and overlapping starts:
  - `rounds_i` = 0 and `rounds_i` = 15 → behave exactly as 12 rounds.
  - A `start_i` pulse at round 5 of a run → ignored: result and timing unchanged.
- Reset mid-run at `round_o` = 5 → outputs 0. A p^8 start issued afterwards completes correctly in 9 cycles. A `start_i` held in the `done_o` cycle → second run follows with no idle gap.
- With `ASCON_PERM_UNROLL2_EN`:
  - p^12 → done after 7 cycles; p^8 → after 5; n = 3 → after 3.
  - `S_o` is identical to the non-unrolled build in every case.

Source files
------------

// File: rtl/ascon_perm.sv
`default_nettype none
// ============================================================================
//  Module      : ascon_perm (with combinational round core ascon_pc)
//  Description : Sequential ASCON permutation driver. Holds the 320-bit state
//                and applies rounds (12-n)..11 through the ascon_pc round
//                core, one round per clock, with a start/done handshake.
//                Optional build macro ASCON_PERM_UNROLL2_EN chains two round
//                cores so that two rounds are applied per clock.
//  Revision    : 1.0 - initial release
// ============================================================================

// ----------------------------------------------------------------------------
// ascon_pc : one ASCON round (constant addition, S-box layer, linear layer).
// State packing: S[319:256] = x0, S[255:192] = x1, ..., S[63:0] = x4.
// ----------------------------------------------------------------------------
module ascon_pc (
    input  logic [3:0]   round_i,
    input  logic [319:0] S_i,
    output logic [319:0] S_o
);

    logic [63:0] w_x0, w_x1, w_x2, w_x3, w_x4;
    logic [63:0] w_t0, w_t1, w_t2, w_t3, w_t4;
    logic [63:0] w_const;

    function automatic logic [63:0] ror(input logic [63:0] v, input int unsigned k);
        return (v >> k) | (v << (64 - k));
    endfunction

    // Round constant: high nibble is the complement of the index, low nibble the index
    assign w_const = {56'd0, 4'hf - round_i, round_i};

    // Bit-sliced S-box followed by the per-word linear diffusion
    always_comb begin
        w_x0 = S_i[319:256];
        w_x1 = S_i[255:192];
        w_x2 = S_i[191:128] ^ w_const;
        w_x3 = S_i[127:64];
        w_x4 = S_i[63:0];

        w_x0 = w_x0 ^ w_x4;
        w_x4 = w_x4 ^ w_x3;
        w_x2 = w_x2 ^ w_x1;

        w_t0 = ~w_x0 & w_x1;
        w_t1 = ~w_x1 & w_x2;
        w_t2 = ~w_x2 & w_x3;
        w_t3 = ~w_x3 & w_x4;
        w_t4 = ~w_x4 & w_x0;

        w_x0 = w_x0 ^ w_t1;
        w_x1 = w_x1 ^ w_t2;
        w_x2 = w_x2 ^ w_t3;
        w_x3 = w_x3 ^ w_t4;
        w_x4 = w_x4 ^ w_t0;

        w_x1 = w_x1 ^ w_x0;
        w_x0 = w_x0 ^ w_x4;
        w_x3 = w_x3 ^ w_x2;
        w_x2 = ~w_x2;

        w_x0 = w_x0 ^ ror(w_x0, 19) ^ ror(w_x0, 28);
        w_x1 = w_x1 ^ ror(w_x1, 61) ^ ror(w_x1, 39);
        w_x2 = w_x2 ^ ror(w_x2, 1)  ^ ror(w_x2, 6);
        w_x3 = w_x3 ^ ror(w_x3, 10) ^ ror(w_x3, 17);
        w_x4 = w_x4 ^ ror(w_x4, 7)  ^ ror(w_x4, 41);

        S_o = {w_x0, w_x1, w_x2, w_x3, w_x4};
    end

endmodule

// ----------------------------------------------------------------------------
// ascon_perm : round sequencer around ascon_pc
// ----------------------------------------------------------------------------
module ascon_perm (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         start_i,
    input  logic [3:0]   rounds_i,
    input  logic [319:0] S_i,
    output logic [319:0] S_o,
    output logic         busy_o,
    output logic         done_o,
    output logic [3:0]   round_o
);

    localparam logic [0:0] c_IDLE    = 1'b0;
    localparam logic [0:0] c_RUN     = 1'b1;
    localparam logic [3:0] c_LAST_RC = 4'd11;

    logic [0:0]   r_state;
    logic [319:0] r_st;
    logic [3:0]   r_rc;
    logic         r_done;
    logic [3:0]   w_n;
    logic [319:0] w_s1;

    // Out-of-range round counts (0, 13..15) fall back to the full p^12
    assign w_n = ((rounds_i == 4'd0) || (rounds_i > 4'd12)) ? 4'd12 : rounds_i;

    ascon_pc u_pc0 (
        .round_i (r_rc),
        .S_i     (r_st),
        .S_o     (w_s1)
    );

`ifdef ASCON_PERM_UNROLL2_EN
    logic [3:0]   w_rc1;
    logic [319:0] w_s2;

    // Second core sees the next index; its output is ignored when rc = 11
    assign w_rc1 = r_rc + 4'd1;

    ascon_pc u_pc1 (
        .round_i (w_rc1),
        .S_i     (w_s1),
        .S_o     (w_s2)
    );

    // Two rounds per edge; a single trailing round finishes from the first core
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= c_IDLE;
            r_st    <= '0;
            r_rc    <= '0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                c_IDLE: begin
                    if (start_i) begin
                        r_st    <= S_i;
                        r_rc    <= 4'd12 - w_n;
                        r_state <= c_RUN;
                    end
                end
                default: begin
                    if (r_rc == c_LAST_RC) begin
                        r_st    <= w_s1;
                        r_rc    <= '0;
                        r_done  <= 1'b1;
                        r_state <= c_IDLE;
                    end else if (r_rc == (c_LAST_RC - 4'd1)) begin
                        r_st    <= w_s2;
                        r_rc    <= '0;
                        r_done  <= 1'b1;
                        r_state <= c_IDLE;
                    end else begin
                        r_st <= w_s2;
                        r_rc <= r_rc + 4'd2;
                    end
                end
            endcase
        end
    end
`else
    // One round per edge; index 11 is always the final round
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= c_IDLE;
            r_st    <= '0;
            r_rc    <= '0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                c_IDLE: begin
                    if (start_i) begin
                        r_st    <= S_i;
                        r_rc    <= 4'd12 - w_n;
                        r_state <= c_RUN;
                    end
                end
                default: begin
                    r_st <= w_s1;
                    if (r_rc == c_LAST_RC) begin
                        r_rc    <= '0;
                        r_done  <= 1'b1;
                        r_state <= c_IDLE;
                    end else begin
                        r_rc <= r_rc + 4'd1;
                    end
                end
            endcase
        end
    end
`endif

    assign S_o     = r_st;
    assign busy_o  = (r_state == c_RUN);
    assign done_o  = r_done;
    assign round_o = (r_state == c_RUN) ? r_rc : 4'd0;

endmodule
`default_nettype wire
